vram_wb_slave: RTL
==================

VRAM_WB_SLAVE -- requirements
Module: vram_wb_slave

Interface
REQ-001 The parameter list SHALL be (name, default, meaning): VRAM_BASE, 'hf80000, byte base address of the frame buffer window.
REQ-002 The parameter list SHALL also contain: DEPTH, 76800, window size in 32-bit words (160 words x 480 lines).
REQ-003 The parameter list SHALL also contain: AW, 17, memory word-address width.
REQ-004 The ports SHALL be (name, direction, width, meaning): wb_clk_i, in, 1, the single clock.
REQ-005 wb_rst_i, in, 1: asynchronous, active-low reset.
REQ-006 wb_cyc_i, in, 1 and wb_stb_i, in, 1: Wishbone cycle and strobe from the frame-buffer fetch master.
REQ-007 wb_we_i, in, 1: write enable; wb_sel_i, in, 4: byte selects.
REQ-008 wb_adr_i, in, 32: byte address; wb_dat_i, in, 32: write data.
REQ-009 wb_dat_o, out, 32: read data; wb_ack_o, wb_err_o, wb_rty_o, out, 1 each: cycle terminations.
REQ-010 mem_en_o, out, 1; mem_we_o, out, 4; mem_adr_o, out, AW; mem_dat_o, out, 32: synchronous single-port RAM command.
REQ-011 mem_dat_i, in, 32: RAM read data, valid the cycle after the clock edge that samples mem_en_o=1 with mem_we_o=0.

Function
REQ-012 A request SHALL be wb_cyc_i & wb_stb_i sampled high in IDLE; it is a hit when VRAM_BASE <= wb_adr_i < VRAM_BASE+4*DEPTH. Word index = (wb_adr_i-VRAM_BASE)>>2; bits [1:0] are ignored.
REQ-013 FSM states SHALL be IDLE, RD_WAIT, ACK, ERR.
REQ-014 Miss: IDLE->ERR; wb_err_o SHALL be high for exactly one cycle; no RAM access; ERR->IDLE.
REQ-015 Hit write: in the request cycle, mem_en_o=1, mem_we_o=wb_sel_i, mem_adr_o=index, mem_dat_o=wb_dat_i (all combinational); FSM->ACK; wb_ack_o SHALL be high the next cycle.
REQ-016 Hit read without prefetch hit: in the request cycle, mem_en_o=1 and mem_we_o=0; FSM->RD_WAIT; wb_dat_o SHALL be registered from mem_dat_i at the end of RD_WAIT; ACK follows, so wb_ack_o is high 2 cycles after the request cycle.
REQ-017 wb_ack_o and wb_err_o SHALL each be single-cycle pulses, registered, never high together; wb_rty_o SHALL be constant 0.
REQ-018 wb_cyc_i or wb_stb_i SHALL be ignored while in ACK or ERR; ACK and ERR always return to IDLE.
REQ-019 wb_cyc_i dropping while in RD_WAIT SHALL abort the transfer: ->IDLE, no ack, wb_dat_o unchanged.
REQ-020 wb_dat_o SHALL hold its last value between acks; write acks do not alter it.
REQ-021 Index arithmetic SHALL be AW bits; the prefetch index SHALL be index+1 and SHALL NOT wrap past DEPTH-1.

Configuration
REQ-022 Macro VRAM_PREFETCH_EN: when defined, the ACK cycle of a read at index A with A+1 < DEPTH SHALL issue a RAM read of A+1 (mem_en_o=1) and set pf_valid with pf_adr=A+1.
REQ-023 With VRAM_PREFETCH_EN, a read request in the following cycle at index pf_adr SHALL be a prefetch hit: no RAM read is issued; wb_dat_o <= mem_dat_i at the end of that cycle; ->ACK; wb_ack_o is high 1 cycle after the request cycle.
REQ-024 With VRAM_PREFETCH_EN, a buffered word SHALL remain usable later via pf_data: pf_data is captured from mem_dat_i the cycle after issue and pf_valid stays set.
REQ-025 With VRAM_PREFETCH_EN, pf_valid SHALL clear on any hit write, on any read whose index differs from pf_adr, and on a miss.
REQ-026 Without VRAM_PREFETCH_EN, ACK SHALL drive mem_en_o=0, every read takes the REQ-016 path, and no pf_* state is built.

Reset
REQ-027 While wb_rst_i=0 (asynchronous assert), the FSM SHALL be in IDLE and wb_ack_o=0, wb_err_o=0, wb_dat_o=0, pf_valid=0, pf_adr=0, pf_data=0.
REQ-028 While wb_rst_i=0, mem_en_o=0 and mem_we_o=0 SHALL hold regardless of bus inputs.
REQ-029 Deassertion of wb_rst_i SHALL take effect at the next wb_clk_i edge; a request cut off mid-transfer by reset is dropped without ack.

Verification
REQ-030 Read at 'hf80000 with RAM[0]='h11223344: wb_ack_o high at cycle +2 and wb_dat_o='h11223344.
REQ-031 Write 'hAABBCCDD, sel 4'b0101, at 'hf80004 over RAM[1]='h0: mem_we_o=4'b0101 in the request cycle, ack at +1; a read-back returns 'h00BB00DD.
REQ-032 Access at 'h000100 and at 'hf80000+4*76800: wb_err_o one-cycle pulse, mem_en_o stays 0, no ack.
REQ-033 With VRAM_PREFETCH_EN, a vcache-style burst of 160 reads from 'hf80000 (stb dropped on ack): reads 2..160 ack at +1, each word matches RAM, and ack spacing is 2 cycles.
REQ-034 With VRAM_PREFETCH_EN: read idx 5, write idx 6='h1, read idx 6 -> miss path (ack +2), data 'h1.
REQ-035 Reset pulse while in RD_WAIT: no ack, all outputs 0; the next read completes normally.

Source files
------------

// File: rtl/vram_wb_slave.sv
// Wishbone slave that maps a 32-bit frame-buffer window onto a synchronous single-port RAM.
// Optional sequential read prefetch is enabled by defining VRAM_PREFETCH_EN.
module vram_wb_slave #(
  parameter logic [31:0] VRAM_BASE = 32'hf80000,
  parameter int          DEPTH     = 76800,
  parameter int          AW        = 17
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [31:0]   mem_dat_o,
  input  logic [31:0]   mem_dat_i
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, ERR} state_t;

  localparam logic [31:0] WIN_END = VRAM_BASE + 32'(4 * DEPTH);

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          req, hit;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_adr;
`ifdef VRAM_PREFETCH_EN
  logic          pf_valid_q, pf_valid_d;
  logic [AW-1:0] pf_adr_q, pf_adr_d;
  logic [31:0]   pf_data_q, pf_data_d;
  logic          pf_fresh_q, pf_fresh_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
`endif

  assign offset = wb_adr_i - VRAM_BASE;
  assign idx    = AW'(offset >> 2);
  assign req    = wb_cyc_i & wb_stb_i;
  assign hit    = (wb_adr_i >= VRAM_BASE) && (wb_adr_i < WIN_END);

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    mem_en  = 1'b0;
    mem_we  = 4'b0000;
    mem_adr = idx;
`ifdef VRAM_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_adr_d   = pf_adr_q;
    // The prefetched word is on mem_dat_i exactly one cycle after its issue.
    pf_data_d  = pf_fresh_q ? mem_dat_i : pf_data_q;
    pf_fresh_d = 1'b0;
    rd_d       = rd_q;
    rd_idx_d   = rd_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            state_d = ERR;
            err_d   = 1'b1;
`ifdef VRAM_PREFETCH_EN
            pf_valid_d = 1'b0;
`endif
          end else if (wb_we_i) begin
            mem_en  = 1'b1;
            mem_we  = wb_sel_i;
            state_d = ACK;
            ack_d   = 1'b1;
`ifdef VRAM_PREFETCH_EN
            pf_valid_d = 1'b0;
            rd_d       = 1'b0;
`endif
          end else begin
`ifdef VRAM_PREFETCH_EN
            rd_d     = 1'b1;
            rd_idx_d = idx;
            if (pf_valid_q && (idx == pf_adr_q)) begin
              dat_d   = pf_fresh_q ? mem_dat_i : pf_data_q;
              state_d = ACK;
              ack_d   = 1'b1;
            end else begin
              mem_en     = 1'b1;
              state_d    = RD_WAIT;
              pf_valid_d = 1'b0;
            end
`else
            mem_en  = 1'b1;
            state_d = RD_WAIT;
`endif
          end
        end
      end
      RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          dat_d   = mem_dat_i;
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
`ifdef VRAM_PREFETCH_EN
        // Fetch the next sequential word while the master consumes this one.
        if (rd_q && (rd_idx_q < AW'(DEPTH - 1))) begin
          mem_en     = 1'b1;
          mem_adr    = rd_idx_q + AW'(1);
          pf_valid_d = 1'b1;
          pf_adr_d   = rd_idx_q + AW'(1);
          pf_fresh_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
`ifdef VRAM_PREFETCH_EN
      pf_valid_q <= 1'b0;
      pf_adr_q   <= '0;
      pf_data_q  <= '0;
      pf_fresh_q <= 1'b0;
      rd_q       <= 1'b0;
      rd_idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
`ifdef VRAM_PREFETCH_EN
      pf_valid_q <= pf_valid_d;
      pf_adr_q   <= pf_adr_d;
      pf_data_q  <= pf_data_d;
      pf_fresh_q <= pf_fresh_d;
      rd_q       <= rd_d;
      rd_idx_q   <= rd_idx_d;
`endif
    end
  end

  // RAM strobes are gated so reset silences them even with a request on the bus.
  assign mem_en_o  = mem_en & wb_rst_i;
  assign mem_we_o  = mem_we & {4{wb_rst_i}};
  assign mem_adr_o = mem_adr;
  assign mem_dat_o = wb_dat_i;
  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_rty_o  = 1'b0;

endmodule
